// File: rtl/alu_wb_arbiter_pkg.sv
// Shared types for the ALU writeback arbiter slice; the scalar types mirror the core's cpu_defs.
package alu_wb_arbiter_pkg;

  localparam int ALU_RS_SIZE = 4;
  localparam int ROB_IDX_W   = 5;

  typedef logic [31:0]          uint32_t;
  typedef logic [ROB_IDX_W-1:0] rob_index_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
  } exception_t;

  typedef struct packed {
    logic       valid;
    uint32_t    data;
    rob_index_t reorder;
    exception_t ex;
  } alu_wb_lane_t;

endpackage

// File: rtl/alu_wb_arbiter_if.sv
// RS-result and writeback-lane bundle between alu_rs, alu_wb_arbiter and the CDB/ROB mux.
interface alu_wb_arbiter_if import alu_wb_arbiter_pkg::*; #(
  parameter int RS_SIZE = ALU_RS_SIZE
);

  logic [RS_SIZE-1:0] data_ready;
  uint32_t            data         [RS_SIZE];
  rob_index_t         data_reorder [RS_SIZE];
  exception_t         ex           [RS_SIZE];
  logic [RS_SIZE-1:0] data_ack;

  logic [1:0]         wb_valid;
  uint32_t            wb_data    [2];
  rob_index_t         wb_reorder [2];
  exception_t         wb_ex      [2];
  logic [1:0]         wb_ack;

  modport slave (
    input  data_ready, data, data_reorder, ex, wb_ack,
    output data_ack, wb_valid, wb_data, wb_reorder, wb_ex
  );

  modport master (
    output data_ready, data, data_reorder, ex, wb_ack,
    input  data_ack, wb_valid, wb_data, wb_reorder, wb_ex
  );

endinterface

// File: rtl/alu_wb_arbiter_rr_pick2.sv
// Combinational rotating-priority finder: first and second requesters at or after rr_ptr.
module alu_wb_arbiter_rr_pick2 import alu_wb_arbiter_pkg::*; #(
  parameter int RS_SIZE = ALU_RS_SIZE,
  parameter int RR_W    = $clog2(RS_SIZE)
) (
  input  logic [RS_SIZE-1:0] req,
  input  logic [RR_W-1:0]    rr_ptr,
  output logic               g0_valid,
  output logic [RR_W-1:0]    g0_idx,
  output logic               g1_valid,
  output logic [RR_W-1:0]    g1_idx
);

  logic [RR_W-1:0] idx_s;
  logic            take0_s;
  logic            take1_s;

  // Walk the request vector in rotated order, keeping the first two hits.
  always_comb begin
    g0_valid = 1'b0;
    g0_idx   = RR_W'(0);
    g1_valid = 1'b0;
    g1_idx   = RR_W'(0);
    idx_s    = RR_W'(0);
    take0_s  = 1'b0;
    take1_s  = 1'b0;
    for (int off = 0; off < RS_SIZE; off++) begin
      idx_s    = RR_W'((int'(rr_ptr) + off) % RS_SIZE);
      take0_s  = req[idx_s] & ~g0_valid;
      take1_s  = req[idx_s] & g0_valid & ~g1_valid;
      g0_idx   = take0_s ? idx_s : g0_idx;
      g1_idx   = take1_s ? idx_s : g1_idx;
      g0_valid = g0_valid | take0_s;
      g1_valid = g1_valid | take1_s;
    end
  end

endmodule

// File: rtl/alu_wb_arbiter.sv
// Picks up to two finished ALU RS entries per cycle into two registered writeback lanes.
// Optional stall counter output perf_stall_cnt is built when ALU_WB_PERF_EN is defined.
module alu_wb_arbiter import alu_wb_arbiter_pkg::*; #(
  parameter int RS_SIZE = ALU_RS_SIZE,
  parameter int RR_W    = $clog2(RS_SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  alu_wb_arbiter_if.slave bus
`ifdef ALU_WB_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt
`endif
);

  logic [RR_W-1:0]    rr_ptr_r;
  logic [RR_W-1:0]    rr_next_s;
  logic [RR_W-1:0]    last_idx_s;
  logic               g0_valid_s;
  logic               g1_valid_s;
  logic [RR_W-1:0]    g0_idx_s;
  logic [RR_W-1:0]    g1_idx_s;
  logic               clear_s;
  logic [1:0]         lane_free_s;
  logic [1:0]         avail_s;
  logic [1:0]         lane_grant_s;
  logic [RR_W-1:0]    lane_idx_s [2];
  logic [RS_SIZE-1:0] data_ack_s;
  alu_wb_lane_t       lane_r     [2];

  alu_wb_arbiter_rr_pick2 #(
    .RS_SIZE (RS_SIZE),
    .RR_W    (RR_W)
  ) u_rr_pick2 (
    .req      (bus.data_ready),
    .rr_ptr   (rr_ptr_r),
    .g0_valid (g0_valid_s),
    .g0_idx   (g0_idx_s),
    .g1_valid (g1_valid_s),
    .g1_idx   (g1_idx_s)
  );

  // Map g0/g1 onto free lanes; a lone free lane always takes g0. Clearing blocks all grants.
  always_comb begin
    clear_s       = rst | flush;
    lane_free_s   = {~lane_r[1].valid | bus.wb_ack[1], ~lane_r[0].valid | bus.wb_ack[0]};
    avail_s       = clear_s ? 2'b00 : lane_free_s;
    lane_grant_s  = 2'b00;
    lane_idx_s[0] = RR_W'(0);
    lane_idx_s[1] = RR_W'(0);
    case (avail_s)
      2'b11: begin
        lane_grant_s  = {g1_valid_s, g0_valid_s};
        lane_idx_s[0] = g0_idx_s;
        lane_idx_s[1] = g1_idx_s;
      end
      2'b01: begin
        lane_grant_s  = {1'b0, g0_valid_s};
        lane_idx_s[0] = g0_idx_s;
      end
      2'b10: begin
        lane_grant_s  = {g0_valid_s, 1'b0};
        lane_idx_s[1] = g0_idx_s;
      end
      default: begin
        lane_grant_s = 2'b00;
      end
    endcase
  end

  // Pop strobes and next pointer; lane1 holds the later pick whenever it is granted.
  always_comb begin
    data_ack_s = {RS_SIZE{1'b0}};
    for (int k = 0; k < 2; k++) begin
      data_ack_s[lane_idx_s[k]] = data_ack_s[lane_idx_s[k]] | lane_grant_s[k];
    end
    last_idx_s = lane_grant_s[1] ? lane_idx_s[1] : lane_idx_s[0];
    rr_next_s  = (last_idx_s == RR_W'(RS_SIZE - 1)) ? RR_W'(0) : last_idx_s + RR_W'(1);
  end

  // Lane registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      rr_ptr_r  <= RR_W'(0);
      lane_r[0] <= '0;
      lane_r[1] <= '0;
    end else begin
      if (|lane_grant_s) begin
        rr_ptr_r <= rr_next_s;
      end
      for (int k = 0; k < 2; k++) begin
        if (lane_grant_s[k]) begin
          lane_r[k] <= '{valid:   1'b1,
                         data:    bus.data[lane_idx_s[k]],
                         reorder: bus.data_reorder[lane_idx_s[k]],
                         ex:      bus.ex[lane_idx_s[k]]};
        end else if (lane_free_s[k]) begin
          lane_r[k].valid <= 1'b0;
        end
      end
    end
  end

  assign bus.data_ack = data_ack_s;

  for (genvar k = 0; k < 2; k++) begin : g_lane_out
    assign bus.wb_valid[k]   = lane_r[k].valid;
    assign bus.wb_data[k]    = lane_r[k].data;
    assign bus.wb_reorder[k] = lane_r[k].reorder;
    assign bus.wb_ex[k]      = lane_r[k].ex;
  end

`ifdef ALU_WB_PERF_EN
  logic [31:0] perf_cnt_r;
  logic        stall_s;

  assign stall_s = |(bus.data_ready & ~data_ack_s);

  // Saturating count of cycles that left a ready entry waiting; flush does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_r <= 32'h0000_0000;
    end else if (stall_s && (perf_cnt_r != 32'hFFFF_FFFF)) begin
      perf_cnt_r <= perf_cnt_r + 32'h0000_0001;
    end
  end

  assign perf_stall_cnt = perf_cnt_r;
`endif

endmodule
